// File: rtl/bcd_entry.sv
// Two-digit BCD keypad entry front end that hands the digits to a BCD-to-binary converter.
// Optional idle timeout for partial entries is compiled in with `define BCD_ENTRY_TIMEOUT_EN.
module bcd_entry #(
    parameter bit          AUTO_CLEAR     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_tick,
    input  logic [3:0] key_code,
    input  logic       conv_ready,
    input  logic       conv_done,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       start,
    output logic       busy,
    output logic [1:0] digit_cnt,
    output logic       err_tick
);

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] bcd1_nxt;
    logic [3:0] bcd0_nxt;
    logic [1:0] digit_cnt_nxt;
    logic       err_nxt;
    logic       start_nxt;
    logic       busy_nxt;

    logic key_digit;
    logic key_clear;
    logic key_enter;
    logic key_bksp;
    logic key_known;
    logic expire;

    assign key_digit = (key_code <= 4'h9);
    assign key_clear = (key_code == 4'hA);
    assign key_enter = (key_code == 4'hB);
    assign key_bksp  = (key_code == 4'hC);
    assign key_known = (key_code <= 4'hC);

`ifdef BCD_ENTRY_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] idle_cnt;

    // A key in the expiry cycle wins: expire requires !key_tick.
    assign expire = (state == ST_ENTRY) && (digit_cnt != 2'd0) && !key_tick &&
                    (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if ((state != ST_ENTRY) || (digit_cnt == 2'd0) || key_tick || expire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expire         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ENTRY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ENTRY: begin
                if (key_tick && key_enter && (digit_cnt != 2'd0)) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (start && conv_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (conv_done) begin
                    state_nxt = ST_ENTRY;
                end
            end
            default: state_nxt = ST_ENTRY;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        bcd1_nxt      = bcd1;
        bcd0_nxt      = bcd0;
        digit_cnt_nxt = digit_cnt;
        err_nxt       = 1'b0;
        case (state)
            ST_ENTRY: begin
                if (key_tick) begin
                    if (key_digit) begin
                        if (digit_cnt < 2'd2) begin
                            bcd1_nxt      = bcd0;
                            bcd0_nxt      = key_code;
                            digit_cnt_nxt = digit_cnt + 2'd1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (key_clear) begin
                        bcd1_nxt      = 4'd0;
                        bcd0_nxt      = 4'd0;
                        digit_cnt_nxt = 2'd0;
                    end else if (key_enter) begin
                        err_nxt = (digit_cnt == 2'd0);
                    end else if (key_bksp) begin
                        if (digit_cnt != 2'd0) begin
                            bcd0_nxt      = bcd1;
                            bcd1_nxt      = 4'd0;
                            digit_cnt_nxt = digit_cnt - 2'd1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end else if (expire) begin
                    bcd1_nxt      = 4'd0;
                    bcd0_nxt      = 4'd0;
                    digit_cnt_nxt = 2'd0;
                    err_nxt       = 1'b1;
                end
            end
            ST_ISSUE: begin
                err_nxt = key_tick && key_known;
            end
            ST_WAIT: begin
                // Keys arriving alongside conv_done are still rejected, not captured.
                err_nxt = key_tick && key_known;
                if (conv_done && AUTO_CLEAR) begin
                    bcd1_nxt      = 4'd0;
                    bcd0_nxt      = 4'd0;
                    digit_cnt_nxt = 2'd0;
                end
            end
            default: ;
        endcase
        start_nxt = (state_nxt == ST_ISSUE);
        busy_nxt  = (state_nxt != ST_ENTRY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcd1      <= 4'd0;
            bcd0      <= 4'd0;
            digit_cnt <= 2'd0;
            start     <= 1'b0;
            busy      <= 1'b0;
            err_tick  <= 1'b0;
        end else begin
            bcd1      <= bcd1_nxt;
            bcd0      <= bcd0_nxt;
            digit_cnt <= digit_cnt_nxt;
            start     <= start_nxt;
            busy      <= busy_nxt;
            err_tick  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_entry.sv
// Directed bench for bcd_entry: digit entry, error keys, converter handshake, reset and timeout.
module tb_bcd_entry;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_tick;
    logic [3:0] key_code;
    logic       conv_ready;
    logic       conv_done;
    logic [3:0] bcd1, bcd0;
    logic       start, busy, err_tick;
    logic [1:0] digit_cnt;
    logic [3:0] h_bcd1, h_bcd0;
    logic       h_start, h_busy, h_err;
    logic [1:0] h_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_entry #(.AUTO_CLEAR(1'b1), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .key_tick(key_tick), .key_code(key_code),
        .conv_ready(conv_ready), .conv_done(conv_done),
        .bcd1(bcd1), .bcd0(bcd0), .start(start), .busy(busy),
        .digit_cnt(digit_cnt), .err_tick(err_tick)
    );

    // Holding variant: digits survive a completed conversion.
    bcd_entry #(.AUTO_CLEAR(1'b0), .TIMEOUT_CYCLES(8)) dut_hold (
        .clk(clk), .reset(reset), .key_tick(key_tick), .key_code(key_code),
        .conv_ready(conv_ready), .conv_done(conv_done),
        .bcd1(h_bcd1), .bcd0(h_bcd0), .start(h_start), .busy(h_busy),
        .digit_cnt(h_cnt), .err_tick(h_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_tick = 1'b1;
        key_code = code;
        tick();
        key_tick = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e1, input logic [3:0] e0,
                           input logic [1:0] ec, input logic es, input logic eb, input logic ee);
        chk({tag, ".bcd1"}, bcd1, e1);
        chk({tag, ".bcd0"}, bcd0, e0);
        chk({tag, ".cnt"}, digit_cnt, ec);
        chk({tag, ".start"}, start, es);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".err"}, err_tick, ee);
    endtask

    initial begin
        reset      = 1'b1;
        key_tick   = 1'b0;
        key_code   = 4'h0;
        conv_ready = 1'b1;
        conv_done  = 1'b0;
        tick();
        tick();
        chk_all("reset", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // 9, 7, enter with converter ready
        press(4'h9);
        chk_all("key9", 4'd0, 4'd9, 2'd1, 1'b0, 1'b0, 1'b0);
        press(4'h7);
        chk_all("key7", 4'd9, 4'd7, 2'd2, 1'b0, 1'b0, 1'b0);
        press(4'hB);
        chk_all("enter97", 4'd9, 4'd7, 2'd2, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("wait97", 4'd9, 4'd7, 2'd2, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk_all("wait97b", 4'd9, 4'd7, 2'd2, 1'b0, 1'b1, 1'b0);
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        chk_all("done97", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("hold.bcd1", h_bcd1, 4'd9);
        chk("hold.bcd0", h_bcd0, 4'd7);
        chk("hold.cnt", h_cnt, 2'd2);
        chk("hold.busy", h_busy, 1'b0);

        // Overflow, backspace, clear, unused codes
        press(4'hA);
        chk("hold.clear", h_cnt, 2'd0);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        chk_all("key3over", 4'd1, 4'd2, 2'd2, 1'b0, 1'b0, 1'b1);
        tick();
        chk("err_one_cycle", err_tick, 1'b0);
        press(4'hC);
        chk_all("bksp1", 4'd0, 4'd1, 2'd1, 1'b0, 1'b0, 1'b0);
        press(4'hC);
        chk_all("bksp2", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        press(4'hC);
        chk_all("bksp_empty", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        press(4'hA);
        chk_all("clear_empty", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        press(4'h6);
        press(4'hE);
        chk_all("unused_E", 4'd0, 4'd6, 2'd1, 1'b0, 1'b0, 1'b0);
        press(4'hA);
        chk_all("clear6", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Empty enter, then stalled converter handshake
        press(4'hB);
        chk_all("enter_empty", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        press(4'h5);
        conv_ready = 1'b0;
        press(4'hB);
        chk_all("enter5", 4'd0, 4'd5, 2'd1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("stall%0d.start", i), start, 1'b1);
        end
        conv_ready = 1'b1;
        tick();
        chk_all("accept5", 4'd0, 4'd5, 2'd1, 1'b0, 1'b1, 1'b0);
        press(4'h5);
        chk_all("key_in_wait", 4'd0, 4'd5, 2'd1, 1'b0, 1'b1, 1'b1);
        press(4'hF);
        chk_all("unused_in_wait", 4'd0, 4'd5, 2'd1, 1'b0, 1'b1, 1'b0);

        // Key 4 coinciding with conv_done is rejected, not captured
        conv_done = 1'b1;
        press(4'h4);
        conv_done = 1'b0;
        chk_all("key_with_done", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
        chk_all("done_in_entry", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Reset in ISSUE overrides simultaneous key and conv_done
        conv_ready = 1'b0;
        press(4'h8);
        press(4'hB);
        chk_all("issue8", 4'd0, 4'd8, 2'd1, 1'b1, 1'b1, 1'b0);
        reset     = 1'b1;
        conv_done = 1'b1;
        press(4'h2);
        reset      = 1'b0;
        conv_done  = 1'b0;
        conv_ready = 1'b1;
        chk_all("reset_issue", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("after_reset", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);

`ifdef BCD_ENTRY_TIMEOUT_EN
        press(4'h3);
        for (int i = 0; i < 7; i++) tick();
        chk_all("to_idle7", 4'd0, 4'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("to_expire", 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("to_err_once", err_tick, 1'b0);
        press(4'h3);
        for (int i = 0; i < 6; i++) tick();
        press(4'h4);
        chk_all("to_key7", 4'd3, 4'd4, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("to_saved", 4'd3, 4'd4, 2'd2, 1'b0, 1'b0, 1'b0);
`else
        press(4'h3);
        for (int i = 0; i < 20; i++) tick();
        chk_all("persist", 4'd0, 4'd3, 2'd1, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
